// File: rtl/iz_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: one shared Euler datapath walks every
// neuron once per step pulse and reports spikes through a valid/ready event port.
module iz_neuron_array #(
  parameter int NUM_NEURONS = 8,
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 6,
  parameter int PARAM_FRAC  = 8,
  parameter int DT_SHIFT    = 2,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic             i_param_we,
  input  logic [IDX_W-1:0] i_param_idx,
  input  logic [2:0]       i_param_sel,
  input  logic [WIDTH-1:0] i_param_data,
  output logic [IDX_W-1:0] o_stim_addr,
  input  logic [7:0]       i_stim_data,
  output logic             o_spike_valid,
  input  logic             i_spike_ready,
  output logic [IDX_W-1:0] o_spike_idx,
  output logic             o_busy,
  output logic             o_step_done,
  output logic             o_step_overrun
);
  localparam int XW = 2*WIDTH + 8;
  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [XW-1:0]    wide_t;

  localparam word_t V_RST  = word_t'(-70 * (1 << FRAC_BITS));
  localparam word_t A_RST  = word_t'(5);
  localparam word_t B_RST  = word_t'(51);
  localparam word_t C_RST  = word_t'(-65 * (1 << FRAC_BITS));
  localparam word_t D_RST  = word_t'(8 * (1 << FRAC_BITS));
  localparam word_t V_PEAK = word_t'(30 * (1 << FRAC_BITS));
  localparam wide_t K_SQ   = wide_t'(41);
  localparam wide_t K_LIN  = wide_t'(5);
  localparam wide_t K_REST = wide_t'(140 * (1 << FRAC_BITS));
  localparam wide_t S_MAX  = wide_t'((1 << (WIDTH-1)) - 1);
  localparam wide_t S_MIN  = wide_t'(-(1 << (WIDTH-1)));

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_UPDATE, S_EMIT, S_DONE} state_t;

  function automatic wide_t sx(input word_t x);
    return {{(XW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic word_t sat(input wide_t x);
    if (x > S_MAX)      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (x < S_MIN) sat = {1'b1, {(WIDTH-1){1'b0}}};
    else                sat = x[WIDTH-1:0];
  endfunction

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_ovr;
  word_t            r_v [NUM_NEURONS];
  word_t            r_u [NUM_NEURONS];
  word_t            r_a [NUM_NEURONS];
  word_t            r_b [NUM_NEURONS];
  word_t            r_c [NUM_NEURONS];
  word_t            r_d [NUM_NEURONS];
  word_t            r_cv, r_cu, r_ca, r_cb, r_cc, r_cd;

  wide_t w_v, w_u, w_a, w_b, w_d, w_stim, w_dv, w_bv, w_du;
  word_t w_v_nxt, w_u_nxt;
  logic  w_spike, w_last, w_wr, w_idx_ok;

  // Non-power-of-two arrays leave unused index codes that must not be written.
  if (NUM_NEURONS == (1 << IDX_W)) begin : g_idx_full
    assign w_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign w_idx_ok = ({1'b0, i_param_idx} < (IDX_W+1)'(NUM_NEURONS));
  end

  assign w_wr   = i_param_we && (r_state == S_IDLE) && w_idx_ok && (i_param_sel < 3'd6);
  assign w_last = (r_idx == IDX_W'(NUM_NEURONS-1));

  always_comb begin
    w_v     = sx(r_cv);
    w_u     = sx(r_cu);
    w_a     = sx(r_ca);
    w_b     = sx(r_cb);
    w_d     = sx(r_cd);
    w_stim  = {{(XW-8){1'b0}}, i_stim_data} << FRAC_BITS;
    w_dv    = ((K_SQ * w_v * w_v) >>> 16) + K_LIN * w_v + K_REST - w_u + w_stim;
    w_bv    = (w_b * w_v) >>> PARAM_FRAC;
    w_du    = (w_a * (w_bv - w_u)) >>> PARAM_FRAC;
    w_spike = (r_cv >= V_PEAK);
    if (w_spike) begin
      w_v_nxt = r_cc;
      w_u_nxt = sat(w_u + w_d);
    end else begin
      w_v_nxt = sat(w_v + (w_dv >>> DT_SHIFT));
      w_u_nxt = sat(w_u + (w_du >>> DT_SHIFT));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_step) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = w_spike ? S_EMIT : (w_last ? S_DONE : S_FETCH);
      S_EMIT:   if (i_spike_ready) w_state_nxt = w_last ? S_DONE : S_FETCH;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ovr   <= 1'b0;
      r_cv    <= '0;
      r_cu    <= '0;
      r_ca    <= '0;
      r_cb    <= '0;
      r_cc    <= '0;
      r_cd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DONE)
        r_idx <= '0;
      else if (r_state != S_IDLE && w_state_nxt == S_FETCH)
        r_idx <= r_idx + IDX_W'(1);
      if (i_step && r_state != S_IDLE)
        r_ovr <= 1'b1;
      if (r_state == S_FETCH) begin
        r_cv <= r_v[r_idx];
        r_cu <= r_u[r_idx];
        r_ca <= r_a[r_idx];
        r_cb <= r_b[r_idx];
        r_cc <= r_c[r_idx];
        r_cd <= r_d[r_idx];
      end
    end
  end

  // Loader writes (IDLE only) and datapath write-back (UPDATE only) never overlap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        r_v[k] <= V_RST;
        r_u[k] <= '0;
        r_a[k] <= A_RST;
        r_b[k] <= B_RST;
        r_c[k] <= C_RST;
        r_d[k] <= D_RST;
      end
    end else if (w_wr) begin
      case (i_param_sel)
        3'd0:    r_a[i_param_idx] <= i_param_data;
        3'd1:    r_b[i_param_idx] <= i_param_data;
        3'd2:    r_c[i_param_idx] <= i_param_data;
        3'd3:    r_d[i_param_idx] <= i_param_data;
        3'd4:    r_v[i_param_idx] <= i_param_data;
        3'd5:    r_u[i_param_idx] <= i_param_data;
        default: ;
      endcase
    end else if (r_state == S_UPDATE) begin
      r_v[r_idx] <= w_v_nxt;
      r_u[r_idx] <= w_u_nxt;
    end
  end

  assign o_stim_addr    = r_idx;
  assign o_spike_idx    = r_idx;
  assign o_spike_valid  = (r_state == S_EMIT);
  assign o_busy         = (r_state != S_IDLE);
  assign o_step_done    = (r_state == S_DONE);
  assign o_step_overrun = r_ovr;
endmodule

// File: tb/tb_iz_neuron_array.sv
// Directed bench for iz_neuron_array: expected spike indices go into a queue that a
// negedge monitor drains on each accepted event; state is checked against hand values.
module tb_iz_neuron_array;
  localparam int N  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          step, we, ready;
  logic [IW-1:0] pidx;
  logic [2:0]    psel;
  logic [15:0]   pdata;
  logic [7:0]    stim;
  logic [IW-1:0] stim_addr, sidx;
  logic          valid, busy, done, ovr;

  logic          step_b, we_b, ready_b;
  logic [IW-1:0] pidx_b;
  logic [2:0]    psel_b;
  logic [15:0]   pdata_b;
  logic [7:0]    stim_b;
  logic [IW-1:0] stim_addr_b, sidx_b;
  logic          valid_b, busy_b, done_b, ovr_b;

  iz_neuron_array #(.NUM_NEURONS(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_param_we(we),
    .i_param_idx(pidx), .i_param_sel(psel), .i_param_data(pdata),
    .o_stim_addr(stim_addr), .i_stim_data(stim), .o_spike_valid(valid),
    .i_spike_ready(ready), .o_spike_idx(sidx), .o_busy(busy),
    .o_step_done(done), .o_step_overrun(ovr));

  iz_neuron_array #(.NUM_NEURONS(N), .DT_SHIFT(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_step(step_b), .i_param_we(we_b),
    .i_param_idx(pidx_b), .i_param_sel(psel_b), .i_param_data(pdata_b),
    .o_stim_addr(stim_addr_b), .i_stim_data(stim_b), .o_spike_valid(valid_b),
    .i_spike_ready(ready_b), .o_spike_idx(sidx_b), .o_busy(busy_b),
    .o_step_done(done_b), .o_step_overrun(ovr_b));

  int errs = 0;
  int checks = 0;
  int acc = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    logic          pst;
    logic [IW-1:0] pid;
    pst = 1'b0;
    pid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pst = 1'b0;
      else begin
        if (pst) begin
          chk("hold_valid", int'(valid), 1);
          chk("hold_idx", int'(sidx), int'(pid));
        end
        if (valid && ready) begin
          acc++;
          if (exp_q.size() == 0) chk("unexpected_spike", int'(sidx), -1);
          else chk("spike_idx", int'(sidx), exp_q.pop_front());
        end
        pst = valid && !ready;
        pid = sidx;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step = 0; we = 0; pidx = '0; psel = '0; pdata = '0; stim = '0; ready = 1;
    step_b = 0; we_b = 0; pidx_b = '0; psel_b = '0; pdata_b = '0; stim_b = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input int idx, input int sel, input int data);
    we = 1; pidx = IW'(idx); psel = 3'(sel); pdata = 16'(data);
    tick();
    we = 0;
  endtask

  task automatic run_step(input int stall, output int n);
    int sc;
    sc = 0;
    ready = (stall == 0);
    step = 1;
    tick();
    step = 0;
    n = 1;
    chk("busy_rise", int'(busy), 1);
    while (!done && n < 100) begin
      if (valid) begin
        sc++;
        if (sc > stall) ready = 1;
      end
      tick();
      n++;
    end
    chk("step_done_seen", int'(done), 1);
    tick();
    ready = 1;
  endtask

  task automatic chk_all(input int ev, input int eu, input int skip);
    for (int i = 0; i < N; i++) begin
      if (i != skip) begin
        chk($sformatf("v[%0d]", i), int'(dut.r_v[i]), ev);
        chk($sformatf("u[%0d]", i), int'(dut.r_u[i]), eu);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, a0, k;
    logic seen;
    ready_b = 1;
    fork
      monitor();
    join_none
    do_reset();

    // reset state
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_stim_addr", int'(stim_addr), 0);
    chk("rst_a", int'(dut.r_a[4]), 5);
    chk("rst_b", int'(dut.r_b[4]), 51);
    chk("rst_c", int'(dut.r_c[4]), -4160);
    chk("rst_d", int'(dut.r_d[4]), 512);
    chk_all(-4480, 0, -1);

    // plain step, reserved selects ignored
    wr(2, 6, 2000);
    wr(2, 7, 2000);
    a0 = acc;
    run_step(0, n);
    chk("t1_latency", n, 17);
    chk("t1_events", acc - a0, 0);
    chk_all(-4701, -5, -1);

    // one spike, consumer ready
    do_reset();
    wr(3, 4, 2000);
    exp_q.push_back(3);
    a0 = acc;
    run_step(0, n);
    chk("t2_latency", n, 18);
    chk("t2_events", acc - a0, 1);
    chk("t2_v3", int'(dut.r_v[3]), -4160);
    chk("t2_u3", int'(dut.r_u[3]), 512);
    chk_all(-4701, -5, 3);

    // one spike, consumer stalls 5 cycles
    do_reset();
    wr(3, 4, 2000);
    exp_q.push_back(3);
    a0 = acc;
    run_step(5, n);
    chk("t3_latency", n, 23);
    chk("t3_events", acc - a0, 1);
    chk("t3_v3", int'(dut.r_v[3]), -4160);
    chk_all(-4701, -5, 3);

    // saturation with dt = 1 ms
    do_reset();
    we_b = 1; pidx_b = '0; psel_b = 3'd4; pdata_b = 16'd1900;
    tick();
    psel_b = 3'd5; pdata_b = 16'h8000;
    tick();
    we_b = 0;
    stim_b = 8'd255;
    step_b = 1;
    tick();
    step_b = 0;
    k = 0;
    seen = 1'b0;
    while (!done_b && k < 100) begin
      tick();
      k++;
      if (valid_b) seen = 1'b1;
    end
    chk("t4_done", int'(done_b), 1);
    chk("t4_no_spike", int'(seen), 0);
    chk("t4_v0_sat", int'(dut_b.r_v[0]), 32767);
    chk("t4_u0", int'(dut_b.r_u[0]), -32121);
    tick();

    // overlapping step and writes while busy
    do_reset();
    a0 = acc;
    step = 1;
    tick();
    step = 0;
    tick();
    we = 1; pidx = 3'd7; psel = 3'd4; pdata = 16'd2000;
    tick();
    pidx = 3'd1; psel = 3'd0; pdata = 16'd100; step = 1;
    tick();
    we = 0; step = 0;
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("t5_done", int'(done), 1);
    chk("t5_ovr", int'(ovr), 1);
    repeat (5) tick();
    chk("t5_idle", int'(busy), 0);
    chk("t5_a1", int'(dut.r_a[1]), 5);
    chk("t5_events", acc - a0, 0);
    chk_all(-4701, -5, -1);

    // reset while an event is pending
    do_reset();
    wr(3, 4, 2000);
    a0 = acc;
    ready = 0;
    step = 1;
    tick();
    step = 0;
    k = 0;
    while (!valid && k < 40) begin
      tick();
      k++;
    end
    chk("t6_valid", int'(valid), 1);
    chk("t6_idx", int'(sidx), 3);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", int'(valid), 0);
    chk("t6_busy_drop", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready = 1;
    tick();
    chk("t6_events", acc - a0, 0);
    chk("t6_ovr", int'(ovr), 0);
    chk_all(-4480, 0, -1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
